// File: rtl/fifo_sync_ctrl.sv
// Synchronous FIFO: storage, wrap-bit pointer control, occupancy and status flags,
// sticky overflow/underflow errors and a one-cycle registered read port.
module fifo_sync_ctrl #(
    parameter int DATA_W   = 8,
    parameter int ADDR_W   = 4,
    parameter int AF_LEVEL = 14,
    parameter int AE_LEVEL = 2
) (
    input  logic              Clk,
    input  logic              Rst_n,
    input  logic              Clr,
    input  logic              Wr_En,
    input  logic [DATA_W-1:0] Din,
    input  logic              Rd_En,
    output logic [DATA_W-1:0] Dout,
    output logic              Dout_Valid,
    output logic              Full,
    output logic              Empty,
    output logic              Almost_Full,
    output logic              Almost_Empty,
    output logic [ADDR_W:0]   Count,
    output logic              Ovf,
    output logic              Unf
);

    localparam int PTR_W = ADDR_W + 1;
    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [PTR_W-1:0] AF_THR = PTR_W'(AF_LEVEL);
    localparam logic [PTR_W-1:0] AE_THR = PTR_W'(AE_LEVEL);

    logic [DATA_W-1:0] mem [DEPTH];

    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W-1:0]  occ;
    logic              wr_acc;
    logic              rd_acc;
    logic [DATA_W-1:0] dout_p1;
    logic              vld_p1;
    logic              ovf_q;
    logic              unf_q;

    // The extra pointer MSB separates "same slot, one lap ahead" (full) from
    // "same slot, same lap" (empty).
    function automatic logic ptr_full(input logic [PTR_W-1:0] wp,
                                      input logic [PTR_W-1:0] rp);
        return (wp[PTR_W-1] != rp[PTR_W-1]) &&
               (wp[ADDR_W-1:0] == rp[ADDR_W-1:0]);
    endfunction

    function automatic logic ptr_empty(input logic [PTR_W-1:0] wp,
                                       input logic [PTR_W-1:0] rp);
        return wp == rp;
    endfunction

    always_comb begin
        occ    = wr_ptr - rd_ptr;
        Empty  = ptr_empty(wr_ptr, rd_ptr);
        Full   = ptr_full(wr_ptr, rd_ptr);
        rd_acc = Rd_En & ~Empty;
        // A write into a full FIFO is accepted only if a read frees a slot this cycle.
        wr_acc = Wr_En & (~Full | rd_acc);
    end

    assign Count        = occ;
    assign Almost_Full  = (occ >= AF_THR);
    assign Almost_Empty = (occ <= AE_THR);

    // Storage: no reset, and Clr suppresses the write.
    always_ff @(posedge Clk) begin
        if (wr_acc && !Clr) begin
            mem[wr_ptr[ADDR_W-1:0]] <= Din;
        end
    end

    // Stage p0 -> p1: pointer update and registered read data.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            dout_p1 <= '0;
            vld_p1  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else if (Clr) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            vld_p1  <= 1'b0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            if (wr_acc) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd_acc) begin
                rd_ptr  <= rd_ptr + 1'b1;
                dout_p1 <= mem[rd_ptr[ADDR_W-1:0]];
            end
            vld_p1 <= rd_acc;
            if (Wr_En && !wr_acc) begin
                ovf_q <= 1'b1;
            end
            if (Rd_En && !rd_acc) begin
                unf_q <= 1'b1;
            end
        end
    end

    assign Dout       = dout_p1;
    assign Dout_Valid = vld_p1;
    assign Ovf        = ovf_q;
    assign Unf        = unf_q;

endmodule

// File: tb/tb_fifo_sync_ctrl.sv
// Directed-vector bench for fifo_sync_ctrl: fill/drain, overflow, underflow,
// full-FIFO simultaneous access, pointer wrap streaming, Clr and async reset.
module tb_fifo_sync_ctrl;

    localparam int DATA_W = 8;
    localparam int ADDR_W = 4;

    logic              Clk;
    logic              Rst_n;
    logic              Clr;
    logic              Wr_En;
    logic [DATA_W-1:0] Din;
    logic              Rd_En;
    logic [DATA_W-1:0] Dout;
    logic              Dout_Valid;
    logic              Full;
    logic              Empty;
    logic              Almost_Full;
    logic              Almost_Empty;
    logic [ADDR_W:0]   Count;
    logic              Ovf;
    logic              Unf;

    int n_vec = 0;
    int n_err = 0;

    fifo_sync_ctrl #(
        .DATA_W(DATA_W), .ADDR_W(ADDR_W), .AF_LEVEL(14), .AE_LEVEL(2)
    ) dut (
        .Clk(Clk), .Rst_n(Rst_n), .Clr(Clr), .Wr_En(Wr_En), .Din(Din),
        .Rd_En(Rd_En), .Dout(Dout), .Dout_Valid(Dout_Valid), .Full(Full),
        .Empty(Empty), .Almost_Full(Almost_Full), .Almost_Empty(Almost_Empty),
        .Count(Count), .Ovf(Ovf), .Unf(Unf)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        Rst_n = 1'b0; Clr = 1'b0; Wr_En = 1'b0; Rd_En = 1'b0; Din = '0;
        #3;
        chk("rst_empty", 32'(Empty), 1);
        chk("rst_full", 32'(Full), 0);
        chk("rst_count", 32'(Count), 0);
        chk("rst_ae", 32'(Almost_Empty), 1);
        chk("rst_af", 32'(Almost_Full), 0);
        chk("rst_dout", 32'(Dout), 0);
        chk("rst_dv", 32'(Dout_Valid), 0);
        chk("rst_ovf", 32'(Ovf), 0);
        chk("rst_unf", 32'(Unf), 0);
        #9 Rst_n = 1'b1;

        // Fill with 0x01..0x10
        for (int i = 1; i <= 16; i++) begin
            Wr_En = 1'b1; Din = 8'(i);
            tick();
            chk("fill_count", 32'(Count), 32'(i));
            chk("fill_af", 32'(Almost_Full), (i >= 14) ? 1 : 0);
            chk("fill_ae", 32'(Almost_Empty), (i <= 2) ? 1 : 0);
            chk("fill_full", 32'(Full), (i == 16) ? 1 : 0);
        end

        // Overflow attempt
        Din = 8'hAA;
        tick();
        chk("ovf_flag", 32'(Ovf), 1);
        chk("ovf_count", 32'(Count), 16);
        chk("ovf_full", 32'(Full), 1);
        Wr_En = 1'b0;

        for (int i = 1; i <= 16; i++) begin
            Rd_En = 1'b1;
            tick();
            chk("drain_dout", 32'(Dout), 32'(i));
            chk("drain_dv", 32'(Dout_Valid), 1);
            chk("drain_count", 32'(Count), 32'(16 - i));
        end
        Rd_En = 1'b0;
        tick();
        chk("idle_dv", 32'(Dout_Valid), 0);
        chk("idle_hold", 32'(Dout), 32'h10);
        chk("idle_empty", 32'(Empty), 1);

        // Underflow with simultaneous write
        Rd_En = 1'b1; Wr_En = 1'b1; Din = 8'h55;
        tick();
        chk("unf_flag", 32'(Unf), 1);
        chk("unf_dv", 32'(Dout_Valid), 0);
        chk("unf_count", 32'(Count), 1);
        Wr_En = 1'b0;
        tick();
        chk("unf_rd55", 32'(Dout), 32'h55);
        chk("unf_rd55_dv", 32'(Dout_Valid), 1);
        chk("unf_empty", 32'(Empty), 1);
        Rd_En = 1'b0;

        // Full FIFO simultaneous read and write
        for (int i = 1; i <= 16; i++) begin
            Wr_En = 1'b1; Din = 8'(32'h20 + i);
            tick();
        end
        chk("f4_full", 32'(Full), 1);
        Rd_En = 1'b1; Din = 8'h77;
        tick();
        chk("f4_count", 32'(Count), 16);
        chk("f4_dout", 32'(Dout), 32'h21);
        chk("f4_full2", 32'(Full), 1);
        Wr_En = 1'b0;
        for (int i = 2; i <= 16; i++) begin
            tick();
            chk("f4_drain", 32'(Dout), 32'h20 + 32'(i));
        end
        tick();
        chk("f4_last77", 32'(Dout), 32'h77);
        chk("f4_empty", 32'(Empty), 1);
        Rd_En = 1'b0;

        // Streaming across the pointer wrap
        Wr_En = 1'b1; Din = 8'h80;
        tick();
        Rd_En = 1'b1;
        for (int i = 0; i < 40; i++) begin
            Din = 8'(32'h81 + i);
            tick();
            chk("strm_dout", 32'(Dout), 32'h80 + 32'(i));
            chk("strm_count", 32'(Count), 1);
            chk("strm_empty", 32'(Empty), 0);
        end
        Wr_En = 1'b0;
        tick();
        chk("strm_last", 32'(Dout), 32'hA8);
        chk("strm_end_empty", 32'(Empty), 1);
        Rd_En = 1'b0;

        // Clr beats a simultaneous write
        for (int i = 0; i < 5; i++) begin
            Wr_En = 1'b1; Din = 8'(32'hC0 + i);
            tick();
        end
        Wr_En = 1'b0;
        chk("pre_clr_count", 32'(Count), 5);
        chk("pre_clr_ovf", 32'(Ovf), 1);
        Clr = 1'b1; Wr_En = 1'b1; Din = 8'h99;
        tick();
        chk("clr_count", 32'(Count), 0);
        chk("clr_empty", 32'(Empty), 1);
        chk("clr_ovf", 32'(Ovf), 0);
        chk("clr_unf", 32'(Unf), 0);
        chk("clr_dout_hold", 32'(Dout), 32'hA8);
        Clr = 1'b0;

        // Async reset with a read in flight
        for (int i = 0; i < 3; i++) begin
            Wr_En = 1'b1; Din = 8'(32'h31 + i);
            tick();
        end
        Wr_En = 1'b0; Rd_En = 1'b1;
        tick();
        Rd_En = 1'b0;
        chk("pre_rst_dv", 32'(Dout_Valid), 1);
        chk("pre_rst_dout", 32'(Dout), 32'h31);
        #2 Rst_n = 1'b0;
        #1;
        chk("arst_count", 32'(Count), 0);
        chk("arst_empty", 32'(Empty), 1);
        chk("arst_dv", 32'(Dout_Valid), 0);
        chk("arst_dout", 32'(Dout), 0);
        chk("arst_ae", 32'(Almost_Empty), 1);
        @(negedge Clk);
        Rst_n = 1'b1;
        tick();
        chk("post_rst_empty", 32'(Empty), 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
